trng_ps_reader: RTL

- PL-side read agent for the TRNG FIFO. It turns a slow, level-only AXI GPIO toggle handshake from PS software into exactly one single-cycle FIFO pop per request.
- Each popped 32-bit word is held stable for PS to sample, together with an acknowledge, a word counter and sticky error flags.
- Sits between the FIFO read port (rd_en/rd_data/empty) and the AXI GPIO channels.

---
 rtl/trng_ps_reader.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/trng_ps_reader.sv
`default_nettype none
// ============================================================================
//  Module   : trng_ps_reader
//  Purpose  : PL-side read agent for the TRNG FIFO. Converts the level-only
//             toggle handshake from PS software (via AXI GPIO) into exactly
//             one single-cycle FIFO pop per request and holds the popped
//             word stable with an acknowledge, a word counter and sticky
//             error flags.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i           system clock
//    rst_ni          asynchronous active-low reset
//    ps_req_i        PS request toggle; each toggle asks for one word
//    ps_clr_i        PS clear level; rising edge clears count and flags
//    fifo_empty_i    FIFO empty flag
//    fifo_rd_data_i  FIFO read data (valid RD_LATENCY cycles after pop)
//    fifo_rd_en_o    FIFO pop strobe (registered, one cycle per request)
//    ps_data_o       last captured word, held until the next capture
//    ps_ack_o        ps_req value of the last completed request
//    ps_busy_o       request accepted or stalled, not yet acknowledged
//    word_count_o    words delivered since reset/clear (wrapping)
//    timeout_flag_o  sticky: a stall lasted STALL_TIMEOUT cycles
//    overrun_flag_o  sticky: ps_req toggled again while busy
//  Parameters
//    SYNC_STAGES     synchroniser depth on ps_req/ps_clr (>= 1)
//    RD_LATENCY      cycles from fifo_rd_en to fifo_rd_data valid (1..4)
//    STALL_TIMEOUT   stall cycles before timeout_flag sets
// ============================================================================
module trng_ps_reader #(
    parameter int SYNC_STAGES   = 2,
    parameter int RD_LATENCY    = 1,
    parameter int STALL_TIMEOUT = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ps_req_i,
    input  logic        ps_clr_i,
    input  logic        fifo_empty_i,
    input  logic [31:0] fifo_rd_data_i,
    output logic        fifo_rd_en_o,
    output logic [31:0] ps_data_o,
    output logic        ps_ack_o,
    output logic        ps_busy_o,
    output logic [31:0] word_count_o,
    output logic        timeout_flag_o,
    output logic        overrun_flag_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int                 STALL_W   = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_TIMEOUT - 1);
    // Extra WAIT cycles beyond the POP cycle; unused when RD_LATENCY == 1.
    localparam logic [1:0]         WAIT_INIT = (RD_LATENCY >= 2) ? 2'(RD_LATENCY - 2) : 2'd0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STALL   = 3'd1,
        S_POP     = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_q;
    logic [SYNC_STAGES-1:0] req_sync_q;
    logic [SYNC_STAGES-1:0] req_sync_d;
    logic [SYNC_STAGES-1:0] clr_sync_q;
    logic [SYNC_STAGES-1:0] clr_sync_d;
    logic                 clr_prev_q;
    logic                 req_tgt_q;
    logic [STALL_W-1:0]   stall_cnt_q;
    logic [1:0]           wait_cnt_q;
    logic                 fifo_rd_en_q;
    logic [31:0]          ps_data_q;
    logic                 ps_ack_q;
    logic                 busy_q;
    logic [31:0]          word_count_q;
    logic                 timeout_q;
    logic                 overrun_q;

    logic req_s;
    logic clr_s;
    logic pending;
    logic clr_pulse;
    logic timeout_set;
    logic overrun_set;

    // ------------------------------------------------------------------
    // Synchroniser shift (works for any depth >= 1)
    // ------------------------------------------------------------------
    always_comb begin
        req_sync_d    = req_sync_q << 1;
        req_sync_d[0] = ps_req_i;
        clr_sync_d    = clr_sync_q << 1;
        clr_sync_d[0] = ps_clr_i;
    end

    assign req_s     = req_sync_q[SYNC_STAGES-1];
    assign clr_s     = clr_sync_q[SYNC_STAGES-1];
    assign pending   = (req_s != ps_ack_q);
    assign clr_pulse = clr_s & ~clr_prev_q;

    // The stall counter parks at STALL_MAX, so the flag keeps re-asserting
    // for as long as the stall lasts; a clear during a long stall therefore
    // does not stick until the FIFO delivers.
    assign timeout_set = (state_q == S_STALL) && (stall_cnt_q == STALL_MAX);
    // Any toggle seen after the target was latched is a request that the
    // single-outstanding handshake cannot represent.
    assign overrun_set = (state_q != S_IDLE) && (req_s != req_tgt_q);

    // ------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            req_sync_q   <= '0;
            clr_sync_q   <= '0;
            clr_prev_q   <= 1'b0;
            req_tgt_q    <= 1'b0;
            stall_cnt_q  <= '0;
            wait_cnt_q   <= 2'd0;
            fifo_rd_en_q <= 1'b0;
            ps_data_q    <= 32'd0;
            ps_ack_q     <= 1'b0;
            busy_q       <= 1'b0;
            word_count_q <= 32'd0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            req_sync_q   <= req_sync_d;
            clr_sync_q   <= clr_sync_d;
            clr_prev_q   <= clr_s;
            fifo_rd_en_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    stall_cnt_q <= '0;
                    if (pending) begin
                        req_tgt_q <= req_s;
                        busy_q    <= 1'b1;
                        if (!fifo_empty_i) begin
                            state_q      <= S_POP;
                            fifo_rd_en_q <= 1'b1;
                        end else begin
                            state_q <= S_STALL;
                        end
                    end
                end

                S_STALL: begin
                    if (!fifo_empty_i) begin
                        state_q      <= S_POP;
                        fifo_rd_en_q <= 1'b1;
                        stall_cnt_q  <= '0;
                    end else if (stall_cnt_q != STALL_MAX) begin
                        stall_cnt_q <= stall_cnt_q + STALL_W'(1);
                    end
                end

                // fifo_rd_en_q is high for exactly this state's cycle.
                S_POP: begin
                    if (RD_LATENCY > 1) begin
                        state_q    <= S_WAIT;
                        wait_cnt_q <= WAIT_INIT;
                    end else begin
                        state_q <= S_CAPTURE;
                    end
                end

                S_WAIT: begin
                    if (wait_cnt_q == 2'd0) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 2'd1;
                    end
                end

                S_CAPTURE: begin
                    ps_data_q    <= fifo_rd_data_i;
                    ps_ack_q     <= req_tgt_q;
                    word_count_q <= word_count_q + 32'd1;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Ordering matters: the clear overrides the capture increment,
            // while a flag being set in the same cycle overrides the clear.
            if (clr_pulse) begin
                word_count_q <= 32'd0;
                timeout_q    <= 1'b0;
                overrun_q    <= 1'b0;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign fifo_rd_en_o   = fifo_rd_en_q;
    assign ps_data_o      = ps_data_q;
    assign ps_ack_o       = ps_ack_q;
    assign ps_busy_o      = busy_q;
    assign word_count_o   = word_count_q;
    assign timeout_flag_o = timeout_q;
    assign overrun_flag_o = overrun_q;

endmodule
`default_nettype wire
